// File: rtl/uart_frame_responder.sv
// Register-access command engine behind a UART FIFO pair: parses A5-framed
// read/write requests, executes them on a small register file, answers with a 5-byte frame.
module uart_frame_responder #(
    parameter int DBIT    = 8,
    parameter int AW      = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] r_data,
    input  logic            rx_empty,
    output logic            rd_uart,
    output logic [DBIT-1:0] W_data,
    output logic            wr_uart,
    input  logic            tx_full,
    output logic [DBIT-1:0] ctrl_reg,
    output logic            frame_done,
    output logic            frame_err
);

    localparam int NREG = 2 ** AW;
    localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, SEND
    } state_t;

    function automatic logic [DBIT-1:0] chk3(input logic [DBIT-1:0] a,
                                             input logic [DBIT-1:0] b,
                                             input logic [DBIT-1:0] c);
        return a ^ b ^ c;
    endfunction

    state_t          state_r, state_next_s;
    logic [DBIT-1:0] cmd_r, addr_r, data_r, chk_r;
    logic [2:0]      idx_r;
    logic [TW-1:0]   tmo_r;
    logic [DBIT-1:0] rsp_r  [5];
    logic [DBIT-1:0] regs_r [NREG];
    logic            in_get_s, pop_s, push_s, timeout_s, is_write_s;
    logic [DBIT-1:0] status_s, rdata_s;

    // FIFO handshakes; reset masks every pop and push in the reset cycle
    always_comb begin
        in_get_s  = (state_r == GET_CMD) || (state_r == GET_ADDR) ||
                    (state_r == GET_DATA) || (state_r == GET_CHK);
        pop_s     = !reset && !rx_empty && ((state_r == IDLE) || in_get_s);
        push_s    = !reset && !tx_full && (state_r == SEND);
        timeout_s = !reset && in_get_s && rx_empty && (tmo_r == TMO_LAST);
    end

    // Request validation in priority order; rdata is only meaningful on success
    always_comb begin
        is_write_s = (cmd_r == 8'h02);
        status_s   = 8'h00;
        rdata_s    = 8'h00;
        if (chk3(cmd_r, addr_r, is_write_s ? data_r : 8'h00) != chk_r) begin
            status_s = 8'h01;
        end else if ((cmd_r != 8'h01) && !is_write_s) begin
            status_s = 8'h02;
        end else if ({1'b0, addr_r} >= 9'(NREG)) begin
            status_s = 8'h03;
        end else begin
            status_s = 8'h00;
        end
        if (status_s != 8'h00) begin
            rdata_s = 8'h00;
        end else if (is_write_s) begin
            rdata_s = data_r;
        end else begin
            rdata_s = regs_r[addr_r[AW-1:0]];
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:     if (pop_s && (r_data == 8'hA5)) state_next_s = GET_CMD;
                      else state_next_s = IDLE;
            GET_CMD:  if (timeout_s) state_next_s = IDLE;
                      else if (pop_s) state_next_s = GET_ADDR;
                      else state_next_s = GET_CMD;
            GET_ADDR: if (timeout_s) state_next_s = IDLE;
                      else if (pop_s) state_next_s = is_write_s ? GET_DATA : GET_CHK;
                      else state_next_s = GET_ADDR;
            GET_DATA: if (timeout_s) state_next_s = IDLE;
                      else if (pop_s) state_next_s = GET_CHK;
                      else state_next_s = GET_DATA;
            GET_CHK:  if (timeout_s) state_next_s = IDLE;
                      else if (pop_s) state_next_s = EXEC;
                      else state_next_s = GET_CHK;
            EXEC:     state_next_s = SEND;
            SEND:     if (push_s && (idx_r == 3'd4)) state_next_s = IDLE;
                      else state_next_s = SEND;
            default:  state_next_s = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        rd_uart    = pop_s;
        wr_uart    = push_s;
        W_data     = (!reset && (state_r == SEND)) ? rsp_r[idx_r] : 8'h00;
        frame_done = push_s && (idx_r == 3'd4);
        frame_err  = timeout_s || (!reset && (state_r == EXEC) && (status_s != 8'h00));
        ctrl_reg   = regs_r[0];
    end

    // State, request capture, idle timer and response latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            tmo_r   <= '0;
            cmd_r   <= 8'h00;
            addr_r  <= 8'h00;
            data_r  <= 8'h00;
            chk_r   <= 8'h00;
            for (int i = 0; i < 5; i++) rsp_r[i] <= 8'h00;
        end else begin
            state_r <= state_next_s;
            // a GET state is only entered through a pop, so clearing on pop covers state entry
            tmo_r   <= (in_get_s && !pop_s && !timeout_s) ? tmo_r + TW'(1) : '0;
            if (pop_s) begin
                case (state_r)
                    GET_CMD:  cmd_r  <= r_data;
                    GET_ADDR: addr_r <= r_data;
                    GET_DATA: data_r <= r_data;
                    GET_CHK:  chk_r  <= r_data;
                    default:  ;
                endcase
            end
            if (state_r == EXEC) begin
                rsp_r[0] <= 8'h5A;
                rsp_r[1] <= status_s;
                rsp_r[2] <= addr_r;
                rsp_r[3] <= rdata_s;
                rsp_r[4] <= chk3(status_s, addr_r, rdata_s);
                idx_r    <= 3'd0;
            end else if (push_s) begin
                idx_r <= (idx_r == 3'd4) ? 3'd0 : idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Register file; written only by a successful write command
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_r[i] <= 8'h00;
        end else if ((state_r == EXEC) && (status_s == 8'h00) && is_write_s) begin
            regs_r[addr_r[AW-1:0]] <= data_r;
        end else begin
            regs_r <= regs_r;
        end
    end

endmodule

// File: tb/tb_uart_frame_responder.sv
// Directed bench for uart_frame_responder: FIFO models on both sides, request
// frames with hand-computed response bytes, error/timeout/backpressure/reset cases.
module tb_uart_frame_responder;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic       tx_full = 1'b0;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart, wr_uart, frame_done, frame_err;
    logic [7:0] W_data, ctrl_reg;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int total = 0, bad = 0;
    int done_cnt = 0, err_cnt = 0, done_base = 0, err_base = 0;

    always #5 clk = ~clk;

    uart_frame_responder #(.DBIT(8), .AW(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
        .W_data(W_data), .wr_uart(wr_uart), .tx_full(tx_full),
        .ctrl_reg(ctrl_reg), .frame_done(frame_done), .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // FIFO models: sample handshakes at the edge, update the queues just after it
    always @(posedge clk) begin : fifo_model
        logic p, w, fd, fe;
        logic [7:0] d;
        p = rd_uart; w = wr_uart; d = W_data; fd = frame_done; fe = frame_err;
        #1;
        if (p && rx_q.size() > 0) void'(rx_q.pop_front());
        if (w) tx_q.push_back(d);
        if (fd) done_cnt++;
        if (fe) err_cnt++;
        rx_empty = (rx_q.size() == 0);
        r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    task automatic send_rx(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) rx_q.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic expect_resp(input string tag, input logic [39:0] exp,
                               input int exp_err, input logic [7:0] exp_ctrl);
        int n = 0;
        bit first = 1'b0;
        while (tx_q.size() < 5 && n < 300) begin
            if (wr_uart && tx_q.size() == 0 && !first) begin
                first = 1'b1;
                check({tag, ".ctrl"}, ctrl_reg, exp_ctrl);
            end
            @(negedge clk);
            n++;
        end
        check({tag, ".first_push"}, first, 1);
        check({tag, ".len"}, tx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s.b%0d", tag, i), (i < tx_q.size()) ? tx_q[i] : 32'hDEAD,
                  exp[8*(4-i) +: 8]);
        check({tag, ".done"}, done_cnt - done_base, 1);
        check({tag, ".err"}, err_cnt - err_base, exp_err);
        done_base = done_cnt;
        err_base  = err_cnt;
        for (int i = 0; i < 5 && tx_q.size() > 0; i++) void'(tx_q.pop_front());
    endtask

    initial begin
        int viol;
        int n;
        send_rx(64'h00, 1);
        repeat (2) @(negedge clk);
        check("rst.rd", rd_uart, 0);
        check("rst.wr", wr_uart, 0);
        check("rst.wdata", W_data, 8'h00);
        check("rst.ctrl", ctrl_reg, 8'h00);
        check("rst.done", frame_done, 0);
        check("rst.err", frame_err, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle.drop", rx_q.size(), 0);
        check("idle.notx", tx_q.size(), 0);

        send_rx(64'hA5_02_03_5C_5D, 5);
        expect_resp("wr3", 40'h5A_00_03_5C_5F, 0, 8'h00);
        send_rx(64'hA5_01_03_02, 4);
        expect_resp("rd3", 40'h5A_00_03_5C_5F, 0, 8'h00);
        send_rx(64'hA5_02_00_81_83, 5);
        expect_resp("wr0", 40'h5A_00_00_81_81, 0, 8'h81);

        send_rx(64'hA5_02_03_5C_00, 5);
        expect_resp("badchk", 40'h5A_01_03_00_02, 1, 8'h81);
        send_rx(64'hA5_01_03_02, 4);
        expect_resp("rd3b", 40'h5A_00_03_5C_5F, 0, 8'h81);
        send_rx(64'hA5_07_03_04, 4);
        expect_resp("badcmd", 40'h5A_02_03_00_01, 1, 8'h81);
        send_rx(64'hA5_01_20_21, 4);
        expect_resp("badaddr", 40'h5A_03_20_00_23, 1, 8'h81);
        send_rx(64'h00_FF_A5_01_03_02, 6);
        expect_resp("resync", 40'h5A_00_03_5C_5F, 0, 8'h81);

        send_rx(64'hA5_01, 2);
        repeat (TMO - 2) @(negedge clk);
        check("tmo.early", err_cnt - err_base, 0);
        repeat (TMO) @(negedge clk);
        check("tmo.err", err_cnt - err_base, 1);
        check("tmo.notx", tx_q.size(), 0);
        check("tmo.nodone", done_cnt - done_base, 0);
        err_base = err_cnt;
        send_rx(64'hA5_01_03_02, 4);
        expect_resp("tmo.next", 40'h5A_00_03_5C_5F, 0, 8'h81);

        tx_full = 1'b1;
        send_rx(64'hA5_01_03_02_A5_01_00_01, 8);
        repeat (12) @(negedge clk);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_uart !== 1'b0 || W_data !== 8'h5A || rd_uart !== 1'b0 || rx_q.size() != 4)
                viol++;
            @(negedge clk);
        end
        check("bp.stall", viol, 0);
        check("bp.rxheld", rx_q.size(), 4);
        check("bp.notx", tx_q.size(), 0);
        tx_full = 1'b0;
        #1;
        expect_resp("bp1", 40'h5A_00_03_5C_5F, 0, 8'h81);
        expect_resp("bp2", 40'h5A_00_00_81_81, 0, 8'h81);

        send_rx(64'hA5_01_03_02, 4);
        n = 0;
        while (tx_q.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsend.two", tx_q.size(), 2);
        reset = 1'b1;
        #1;
        check("rsend.wr", wr_uart, 0);
        check("rsend.wdata", W_data, 8'h00);
        @(negedge clk);
        check("rsend.ctrl", ctrl_reg, 8'h00);
        check("rsend.done", frame_done, 0);
        check("rsend.err", frame_err, 0);
        check("rsend.held", tx_q.size(), 2);
        reset = 1'b0;
        @(negedge clk);
        tx_q.delete();
        done_base = done_cnt;
        err_base  = err_cnt;
        send_rx(64'hA5_01_03_02, 4);
        expect_resp("post.rd3", 40'h5A_00_03_00_03, 0, 8'h00);
        send_rx(64'hA5_01_00_01, 4);
        expect_resp("post.rd0", 40'h5A_00_00_00_00, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
